vx_fetch_stage: RTL and testbench

Instruction fetch stage sitting directly downstream of the warp scheduler. It accepts scheduled warps (wid, PC, thread mask, uuid), issues one instruction-cache read per warp, and records per-warp context in a tag table. When the I-cache response returns, it rejoins the instruction word with its context and hands it to decode over a valid/ready interface. Each warp has at most one fetch in flight; the block never reorders traffic within a warp.

---
 rtl/vx_fetch_pkg.sv | 27 ++
 rtl/vx_fetch_tag_table.sv | 25 ++
 rtl/vx_fetch_stage.sv | 140 ++++++++++++++
 tb/tb_vx_fetch_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Context, request bundle and warp-id width helper.
package vx_fetch_pkg;

  localparam int FETCH_XLEN    = 32;
  localparam int FETCH_THREADS = 4;
  localparam int FETCH_UUID_W  = 44;
  localparam int FETCH_WARPS   = 4;

  function automatic int nw_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FETCH_NW_W = nw_width(FETCH_WARPS);

  typedef struct packed {
    logic [FETCH_XLEN-1:0]    pc;
    logic [FETCH_THREADS-1:0] tmask;
    logic [FETCH_UUID_W-1:0]  uuid;
  } fetch_ctx_t;

  typedef struct packed {
    logic [FETCH_XLEN-3:0] addr;
    logic [FETCH_NW_W-1:0] tag;
  } fetch_req_t;

endpackage

// File: rtl/vx_fetch_tag_table.sv
// Per-warp fetch context storage.
// One write port, one asynchronous read port, no reset.
module vx_fetch_tag_table
  import vx_fetch_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int NW_WIDTH  = 2
) (
  input  logic                clk,
  input  logic                we,
  input  logic [NW_WIDTH-1:0] waddr,
  input  fetch_ctx_t          wdata,
  input  logic [NW_WIDTH-1:0] raddr,
  output fetch_ctx_t          rdata
);

  fetch_ctx_t mem [NUM_WARPS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vx_fetch_stage.sv
// Instruction fetch stage: scheduler -> I-cache -> decode.
// One fetch in flight per warp; context rejoined by tag.
module vx_fetch_stage
  import vx_fetch_pkg::*;
#(
  parameter int NUM_WARPS     = 4,
  parameter int NUM_THREADS   = 4,
  parameter int XLEN          = 32,
  parameter int UUID_WIDTH    = 44,
  parameter int PERF_CTR_BITS = 44,
  localparam int NW_WIDTH     = nw_width(NUM_WARPS)
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     sched_valid,
  output logic                     sched_ready,
  input  logic [NW_WIDTH-1:0]      sched_wid,
  input  logic [XLEN-1:0]          sched_pc,
  input  logic [NUM_THREADS-1:0]   sched_tmask,
  input  logic [UUID_WIDTH-1:0]    sched_uuid,

  output logic                     icache_req_valid,
  input  logic                     icache_req_ready,
  output logic [XLEN-3:0]          icache_req_addr,
  output logic [NW_WIDTH-1:0]      icache_req_tag,

  input  logic                     icache_rsp_valid,
  output logic                     icache_rsp_ready,
  input  logic [31:0]              icache_rsp_data,
  input  logic [NW_WIDTH-1:0]      icache_rsp_tag,

  output logic                     fetch_valid,
  input  logic                     fetch_ready,
  output logic [NW_WIDTH-1:0]      fetch_wid,
  output logic [XLEN-1:0]          fetch_pc,
  output logic [NUM_THREADS-1:0]   fetch_tmask,
  output logic [UUID_WIDTH-1:0]    fetch_uuid,
  output logic [31:0]              fetch_instr,

  output logic                     busy,
  output logic [PERF_CTR_BITS-1:0] perf_fetch_stalls
);

  logic [NUM_WARPS-1:0] pending;
  logic [NUM_WARPS-1:0] pending_n;
  logic                 req_valid;
  fetch_req_t           req;
  fetch_ctx_t           wr_ctx;
  fetch_ctx_t           rd_ctx;
  logic                 sched_fire;
  logic                 rsp_fire;

  assign sched_ready = !pending[sched_wid]
                    && (!req_valid || icache_req_ready);
  assign sched_fire  = sched_valid && sched_ready;

  assign icache_rsp_ready = !fetch_valid || fetch_ready;
  assign rsp_fire         = icache_rsp_valid && icache_rsp_ready;

  assign wr_ctx.pc    = sched_pc;
  assign wr_ctx.tmask = sched_tmask;
  assign wr_ctx.uuid  = sched_uuid;

  vx_fetch_tag_table #(
    .NUM_WARPS (NUM_WARPS),
    .NW_WIDTH  (NW_WIDTH)
  ) u_tag_table (
    .clk   (clk),
    .we    (sched_fire),
    .waddr (sched_wid),
    .wdata (wr_ctx),
    .raddr (icache_rsp_tag),
    .rdata (rd_ctx)
  );

  // A warp cannot be scheduled while its own response fires,
  // so set and clear never target the same bit.
  always_comb begin
    pending_n = pending;
    if (rsp_fire)   pending_n[icache_rsp_tag] = 1'b0;
    if (sched_fire) pending_n[sched_wid]      = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_n;
  end

  always_ff @(posedge clk) begin
    if (reset)                 req_valid <= 1'b0;
    else if (sched_fire)       req_valid <= 1'b1;
    else if (icache_req_ready) req_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (sched_fire) begin
      req.addr <= sched_pc[XLEN-1:2];
      req.tag  <= sched_wid;
    end
  end

  assign icache_req_valid = req_valid;
  assign icache_req_addr  = req.addr;
  assign icache_req_tag   = req.tag;

  always_ff @(posedge clk) begin
    if (reset)            fetch_valid <= 1'b0;
    else if (rsp_fire)    fetch_valid <= 1'b1;
    else if (fetch_ready) fetch_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rsp_fire) begin
      fetch_wid   <= icache_rsp_tag;
      fetch_pc    <= rd_ctx.pc;
      fetch_tmask <= rd_ctx.tmask;
      fetch_uuid  <= rd_ctx.uuid;
      fetch_instr <= icache_rsp_data;
    end
  end

  assign busy = (|pending) || req_valid || fetch_valid;

  always_ff @(posedge clk) begin
    if (reset)
      perf_fetch_stalls <= '0;
    else if (sched_valid && !sched_ready)
      perf_fetch_stalls <= perf_fetch_stalls
                         + PERF_CTR_BITS'(1);
  end

  always @(posedge clk) begin
    if (!reset && rsp_fire)
      rsp_tag_pending: assert (pending[icache_rsp_tag]);
    if (!reset && sched_fire)
      sched_pc_aligned: assert (sched_pc[1:0] == 2'b00);
  end

endmodule

// File: tb/tb_vx_fetch_stage.sv
// Directed bench for vx_fetch_stage.
// Drives #1 after posedge, checks on the falling edge.
module tb_vx_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        sched_valid;
  logic        sched_ready;
  logic [1:0]  sched_wid;
  logic [31:0] sched_pc;
  logic [3:0]  sched_tmask;
  logic [43:0] sched_uuid;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [29:0] icache_req_addr;
  logic [1:0]  icache_req_tag;
  logic        icache_rsp_valid;
  logic        icache_rsp_ready;
  logic [31:0] icache_rsp_data;
  logic [1:0]  icache_rsp_tag;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [1:0]  fetch_wid;
  logic [31:0] fetch_pc;
  logic [3:0]  fetch_tmask;
  logic [43:0] fetch_uuid;
  logic [31:0] fetch_instr;
  logic        busy;
  logic [43:0] perf_fetch_stalls;

  int checks = 0;
  int errors = 0;
  int rq3 = 0;
  int n3;

  always #5 clk = ~clk;

  vx_fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .sched_valid       (sched_valid),
    .sched_ready       (sched_ready),
    .sched_wid         (sched_wid),
    .sched_pc          (sched_pc),
    .sched_tmask       (sched_tmask),
    .sched_uuid        (sched_uuid),
    .icache_req_valid  (icache_req_valid),
    .icache_req_ready  (icache_req_ready),
    .icache_req_addr   (icache_req_addr),
    .icache_req_tag    (icache_req_tag),
    .icache_rsp_valid  (icache_rsp_valid),
    .icache_rsp_ready  (icache_rsp_ready),
    .icache_rsp_data   (icache_rsp_data),
    .icache_rsp_tag    (icache_rsp_tag),
    .fetch_valid       (fetch_valid),
    .fetch_ready       (fetch_ready),
    .fetch_wid         (fetch_wid),
    .fetch_pc          (fetch_pc),
    .fetch_tmask       (fetch_tmask),
    .fetch_uuid        (fetch_uuid),
    .fetch_instr       (fetch_instr),
    .busy              (busy),
    .perf_fetch_stalls (perf_fetch_stalls)
  );

  // Request handshakes for warp 3, taken at the edge itself.
  always @(posedge clk) begin
    if (!reset && icache_req_valid && icache_req_ready
        && icache_req_tag == 2'd3)
      rq3++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic sched(input logic v,
                       input logic [1:0] w,
                       input logic [31:0] pc,
                       input logic [3:0] tm,
                       input logic [43:0] id);
    sched_valid = v;
    sched_wid   = w;
    sched_pc    = pc;
    sched_tmask = tm;
    sched_uuid  = id;
  endtask

  task automatic rsp(input logic v,
                     input logic [1:0] t,
                     input logic [31:0] d);
    icache_rsp_valid = v;
    icache_rsp_tag   = t;
    icache_rsp_data  = d;
  endtask

  initial begin
    reset = 1'b1;
    sched(1'b0, 2'd0, 32'h0, 4'h0, 44'h0);
    rsp(1'b0, 2'd0, 32'h0);
    icache_req_ready = 1'b1;
    fetch_ready      = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    settle();
    chk("rst_sched_ready", sched_ready, 1);
    chk("rst_req_valid", icache_req_valid, 0);
    chk("rst_rsp_ready", icache_rsp_ready, 1);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perf", perf_fetch_stalls, 0);

    // basic fetch
    step(); sched(1, 0, 32'h8000_0000, 4'b0001, 1);
    settle();
    chk("basic_sched_ready", sched_ready, 1);
    step(); sched(0, 0, 0, 0, 0);
    settle();
    chk("basic_req_valid", icache_req_valid, 1);
    chk("basic_req_addr", icache_req_addr, 32'h2000_0000);
    chk("basic_req_tag", icache_req_tag, 0);
    chk("basic_busy", busy, 1);
    step(); rsp(1, 0, 32'h0000_0013);
    settle();
    chk("basic_rsp_ready", icache_rsp_ready, 1);
    chk("basic_no_out_yet", fetch_valid, 0);
    step(); rsp(0, 0, 0);
    settle();
    chk("basic_fvalid", fetch_valid, 1);
    chk("basic_wid", fetch_wid, 0);
    chk("basic_pc", fetch_pc, 32'h8000_0000);
    chk("basic_tmask", fetch_tmask, 4'b0001);
    chk("basic_uuid", fetch_uuid, 1);
    chk("basic_instr", fetch_instr, 32'h13);
    step(); settle();
    chk("basic_drained", fetch_valid, 0);
    chk("basic_idle", busy, 0);

    // per-warp blocking
    step(); sched(1, 2, 32'h100, 4'b0011, 2);
    settle();
    chk("blk_first_ready", sched_ready, 1);
    step(); sched(1, 2, 32'h200, 4'b0011, 3);
    settle();
    chk("blk_refused", sched_ready, 0);
    chk("blk_perf0", perf_fetch_stalls, 0);
    step(); settle();
    chk("blk_perf1", perf_fetch_stalls, 1);
    chk("blk_still_refused", sched_ready, 0);
    step(); settle();
    chk("blk_perf2", perf_fetch_stalls, 2);
    step(); sched(1, 3, 32'h300, 4'b1111, 4);
    settle();
    chk("blk_w3_ready", sched_ready, 1);
    chk("blk_perf3", perf_fetch_stalls, 3);
    step(); sched(0, 0, 0, 0, 0);
    settle();
    chk("blk_perf_hold", perf_fetch_stalls, 3);
    chk("blk_req_tag3", icache_req_tag, 3);
    step(); rsp(1, 2, 32'hA);
    settle();
    step(); rsp(1, 3, 32'hB);
    settle();
    chk("blk_out_w2", fetch_wid, 2);
    chk("blk_out_pc2", fetch_pc, 32'h100);
    step(); rsp(0, 0, 0);
    settle();
    chk("blk_out_w3", fetch_wid, 3);
    chk("blk_out_uuid3", fetch_uuid, 4);
    step(); settle();

    // out-of-order return
    step(); sched(1, 1, 32'h1000, 4'b0010, 5);
    settle();
    step(); sched(1, 3, 32'h3000, 4'b1000, 6);
    settle();
    chk("ooo_w3_ready", sched_ready, 1);
    step(); sched(0, 0, 0, 0, 0); rsp(1, 3, 32'h33);
    settle();
    step(); rsp(1, 1, 32'h11);
    settle();
    chk("ooo_first_wid", fetch_wid, 3);
    chk("ooo_first_pc", fetch_pc, 32'h3000);
    chk("ooo_first_uuid", fetch_uuid, 6);
    chk("ooo_first_instr", fetch_instr, 32'h33);
    step(); rsp(0, 0, 0);
    settle();
    chk("ooo_second_wid", fetch_wid, 1);
    chk("ooo_second_pc", fetch_pc, 32'h1000);
    chk("ooo_second_uuid", fetch_uuid, 5);
    step(); settle();
    chk("ooo_drained", fetch_valid, 0);

    // decode backpressure
    step(); sched(1, 0, 32'h2000, 4'b0001, 11);
    settle();
    step(); sched(1, 1, 32'h2100, 4'b0010, 12);
    settle();
    step(); sched(1, 2, 32'h2200, 4'b0100, 13);
    settle();
    step(); sched(0, 0, 0, 0, 0);
    fetch_ready = 1'b0; rsp(1, 0, 32'hA0);
    settle();
    chk("bp_rsp_ready0", icache_rsp_ready, 1);
    step(); rsp(1, 1, 32'hA1);
    settle();
    chk("bp_fvalid", fetch_valid, 1);
    chk("bp_wid", fetch_wid, 0);
    chk("bp_rsp_blocked", icache_rsp_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      chk("bp_hold_rsp_ready", icache_rsp_ready, 0);
      chk("bp_hold_wid", fetch_wid, 0);
      chk("bp_hold_instr", fetch_instr, 32'hA0);
      chk("bp_hold_uuid", fetch_uuid, 11);
    end
    step(); fetch_ready = 1'b1;
    settle();
    chk("bp_release_rsp_ready", icache_rsp_ready, 1);
    chk("bp_release_wid", fetch_wid, 0);
    step(); rsp(1, 2, 32'hA2);
    settle();
    chk("bp_drain1_wid", fetch_wid, 1);
    chk("bp_drain1_instr", fetch_instr, 32'hA1);
    chk("bp_drain1_pc", fetch_pc, 32'h2100);
    step(); rsp(0, 0, 0);
    settle();
    chk("bp_drain2_wid", fetch_wid, 2);
    chk("bp_drain2_instr", fetch_instr, 32'hA2);
    chk("bp_drain2_uuid", fetch_uuid, 13);
    step(); settle();
    chk("bp_idle", busy, 0);

    // cache stall
    n3 = rq3;
    step(); icache_req_ready = 1'b0;
    sched(1, 3, 32'h4000, 4'b1111, 7);
    settle();
    chk("cs_accept", sched_ready, 1);
    step(); sched(1, 0, 32'h5000, 4'b0001, 8);
    settle();
    chk("cs_req_valid", icache_req_valid, 1);
    chk("cs_addr_a", icache_req_addr, 32'h1000);
    chk("cs_tag_a", icache_req_tag, 3);
    chk("cs_sched_blocked_a", sched_ready, 0);
    step(); settle();
    chk("cs_addr_b", icache_req_addr, 32'h1000);
    chk("cs_sched_blocked_b", sched_ready, 0);
    step(); settle();
    chk("cs_tag_c", icache_req_tag, 3);
    chk("cs_sched_blocked_c", sched_ready, 0);
    step(); icache_req_ready = 1'b1;
    settle();
    chk("cs_release_ready", sched_ready, 1);
    step(); sched(0, 0, 0, 0, 0);
    settle();
    chk("cs_next_tag", icache_req_tag, 0);
    chk("cs_next_addr", icache_req_addr, 32'h1400);
    chk("cs_issued_once", rq3, n3 + 1);
    step(); rsp(1, 3, 32'h43);
    settle();
    step(); rsp(1, 0, 32'h50);
    settle();
    chk("cs_out_w3", fetch_wid, 3);
    chk("cs_out_pc3", fetch_pc, 32'h4000);
    chk("cs_out_instr3", fetch_instr, 32'h43);
    step(); rsp(0, 0, 0);
    settle();
    chk("cs_out_w0", fetch_wid, 0);
    chk("cs_out_pc0", fetch_pc, 32'h5000);
    step(); settle();
    chk("cs_still_once", rq3, n3 + 1);

    // same-cycle response/schedule hazard
    step(); sched(1, 1, 32'h6000, 4'b0010, 9);
    settle();
    step(); sched(0, 0, 0, 0, 0);
    settle();
    step(); rsp(1, 1, 32'h61);
    sched(1, 1, 32'h7000, 4'b0010, 10);
    settle();
    chk("hz_refused", sched_ready, 0);
    step(); rsp(0, 0, 0);
    settle();
    chk("hz_accept_next", sched_ready, 1);
    chk("hz_old_wid", fetch_wid, 1);
    chk("hz_old_pc", fetch_pc, 32'h6000);
    chk("hz_old_uuid", fetch_uuid, 9);
    step(); sched(0, 0, 0, 0, 0);
    settle();
    chk("hz_req_valid", icache_req_valid, 1);
    chk("hz_req_addr", icache_req_addr, 32'h1C00);
    chk("hz_req_tag", icache_req_tag, 1);
    step(); rsp(1, 1, 32'h71);
    settle();
    step(); rsp(0, 0, 0);
    settle();
    chk("hz_new_pc", fetch_pc, 32'h7000);
    chk("hz_new_uuid", fetch_uuid, 10);
    chk("hz_new_instr", fetch_instr, 32'h71);
    step(); settle();

    // reset with fetches in flight
    step(); sched(1, 2, 32'h8000, 4'b0001, 14);
    settle();
    step(); sched(1, 3, 32'h9000, 4'b0001, 15);
    settle();
    step(); sched(0, 0, 0, 0, 0);
    settle();
    chk("mr_busy_before", busy, 1);
    step(); reset = 1'b1;
    settle();
    step(); reset = 1'b0;
    settle();
    chk("mr_busy", busy, 0);
    chk("mr_fvalid", fetch_valid, 0);
    chk("mr_req_valid", icache_req_valid, 0);
    chk("mr_sched_ready", sched_ready, 1);
    chk("mr_perf", perf_fetch_stalls, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
